// File: rtl/qsys_serial_arbiter.sv
// ============================================================================
// qsys_serial_arbiter : two-port Avalon-MM front end sharing one serial link
// Revision: 1.0
// ============================================================================
`default_nettype none

module qsys_serial_arbiter #(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        rsi_MRST_reset,
    input  logic        csi_MCLK_clk,
    input  logic [7:0]  avs_a_address,
    input  logic [31:0] avs_a_writedata,
    input  logic        avs_a_write,
    input  logic        avs_a_read,
    output logic [31:0] avs_a_readdata,
    output logic        avs_a_waitrequest,
    input  logic [7:0]  avs_b_address,
    input  logic [31:0] avs_b_writedata,
    input  logic        avs_b_write,
    input  logic        avs_b_read,
    output logic [31:0] avs_b_readdata,
    output logic        avs_b_waitrequest,
    output logic        sdo,
    output logic        sle,
    input  logic        sdi,
    output logic        clk,
    input  logic        srdy,
    output logic        timeout_pulse
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT    = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_RECV     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic        c_PORT_A     = 1'b0;
    localparam logic        c_PORT_B     = 1'b1;
    localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [6:0]  c_LAST_BIT   = 7'd64;
    localparam logic [4:0]  c_LAST_RX    = 5'd31;

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_rw;
    logic [63:0] r_frame;
    logic [6:0]  r_bit_cnt;
    logic [15:0] r_timer;
    logic [4:0]  r_rx_cnt;
    logic [30:0] r_shift_in;
    logic        r_sdo;
    logic        r_sle;
    logic        r_to_pulse;
    logic [31:0] r_rdata_a;
    logic [31:0] r_rdata_b;

    logic        w_req_a;
    logic        w_req_b;
    logic        w_grant_next;
    logic [7:0]  w_sel_addr;
    logic [31:0] w_sel_data;
    logic        w_sel_wr;
    logic [64:0] w_frame;
    logic [31:0] w_shift_next;

    // A simultaneous read+write is treated as a write.
    assign w_req_a = avs_a_read | avs_a_write;
    assign w_req_b = avs_b_read | avs_b_write;

    // On a tie, the port that did not win last time goes first.
    assign w_grant_next = (w_req_a & w_req_b) ? ~r_last_grant : w_req_b;

    assign w_sel_addr   = (r_grant == c_PORT_B) ? avs_b_address   : avs_a_address;
    assign w_sel_data   = (r_grant == c_PORT_B) ? avs_b_writedata : avs_a_writedata;
    assign w_sel_wr     = (r_grant == c_PORT_B) ? avs_b_write     : avs_a_write;
    assign w_frame      = {w_sel_wr, 24'd0, w_sel_addr, (w_sel_wr ? w_sel_data : 32'd0)};
    assign w_shift_next = {r_shift_in, sdi};

    assign avs_a_waitrequest = w_req_a & ~((r_state == S_DONE) & (r_grant == c_PORT_A));
    assign avs_b_waitrequest = w_req_b & ~((r_state == S_DONE) & (r_grant == c_PORT_B));

    assign avs_a_readdata = r_rdata_a;
    assign avs_b_readdata = r_rdata_b;
    assign sdo            = r_sdo;
    assign sle            = r_sle;
    assign timeout_pulse  = r_to_pulse;
    assign clk            = csi_MCLK_clk;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_state      <= S_IDLE;
            r_grant      <= c_PORT_A;
            r_last_grant <= c_PORT_B;
            r_rw         <= 1'b0;
            r_frame      <= '0;
            r_bit_cnt    <= '0;
            r_timer      <= '0;
            r_rx_cnt     <= '0;
            r_shift_in   <= '0;
            r_sdo        <= 1'b0;
            r_sle        <= 1'b0;
            r_to_pulse   <= 1'b0;
            r_rdata_a    <= '0;
            r_rdata_b    <= '0;
        end else begin
            r_to_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_a | w_req_b) begin
                        r_grant <= w_grant_next;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Bit 64 goes straight to sdo; the rest is held for shifting.
                    r_rw      <= w_sel_wr;
                    r_frame   <= w_frame[63:0];
                    r_sdo     <= w_frame[64];
                    r_sle     <= 1'b1;
                    r_bit_cnt <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_sle   <= 1'b0;
                        r_sdo   <= 1'b0;
                        r_timer <= '0;
                        r_state <= S_WAIT_RDY;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                        r_sdo     <= r_frame[63];
                        r_frame   <= {r_frame[62:0], 1'b0};
                    end
                end
                S_WAIT_RDY: begin
                    if (srdy) begin
                        r_rx_cnt <= '0;
                        r_state  <= r_rw ? S_DONE : S_RECV;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_to_pulse <= 1'b1;
                        if (r_grant == c_PORT_B) r_rdata_b <= ERR_DATA;
                        else                     r_rdata_a <= ERR_DATA;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_RECV: begin
                    r_shift_in <= w_shift_next[30:0];
                    r_rx_cnt   <= r_rx_cnt + 5'd1;
                    // Readdata is loaded on entry to DONE so it is valid while waitrequest is low.
                    if (r_rx_cnt == c_LAST_RX) begin
                        if (r_grant == c_PORT_B) r_rdata_b <= w_shift_next;
                        else                     r_rdata_a <= w_shift_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qsys_serial_arbiter.sv
// ============================================================================
// tb_qsys_serial_arbiter : randomized bench with a remote-memory peripheral model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_qsys_serial_arbiter;

    logic        csi_MCLK_clk = 1'b0;
    logic        rsi_MRST_reset;
    logic [7:0]  avs_a_address, avs_b_address;
    logic [31:0] avs_a_writedata, avs_b_writedata;
    logic        avs_a_write, avs_a_read, avs_b_write, avs_b_read;
    logic [31:0] avs_a_readdata, avs_b_readdata;
    logic        avs_a_waitrequest, avs_b_waitrequest;
    logic        sdo, sle, sdi, sclk, srdy, timeout_pulse;

    always #5 csi_MCLK_clk = ~csi_MCLK_clk;

    qsys_serial_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .rsi_MRST_reset    (rsi_MRST_reset),
        .csi_MCLK_clk      (csi_MCLK_clk),
        .avs_a_address     (avs_a_address),
        .avs_a_writedata   (avs_a_writedata),
        .avs_a_write       (avs_a_write),
        .avs_a_read        (avs_a_read),
        .avs_a_readdata    (avs_a_readdata),
        .avs_a_waitrequest (avs_a_waitrequest),
        .avs_b_address     (avs_b_address),
        .avs_b_writedata   (avs_b_writedata),
        .avs_b_write       (avs_b_write),
        .avs_b_read        (avs_b_read),
        .avs_b_readdata    (avs_b_readdata),
        .avs_b_waitrequest (avs_b_waitrequest),
        .sdo               (sdo),
        .sle               (sle),
        .sdi               (sdi),
        .clk               (sclk),
        .srdy              (srdy),
        .timeout_pulse     (timeout_pulse)
    );

    int vectors = 0;
    int miscompares = 0;

    // Remote peripheral: mode 0 = handshake after resp_delay, 1 = silent, 2 = srdy tied high
    int          resp_mode = 2;
    int          resp_delay = 0;
    logic [31:0] rem_mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [64:0] frames [$];
    int          flens [$];
    int          order_q [$];
    int          to_cnt = 0;
    int          viol_cnt = 0;
    logic [64:0] cap;
    int          cap_len = 0;
    int          ph = 0;
    int          pcnt = 0;
    logic [31:0] prd;
    logic        p_rd;
    logic [31:0] exp_rd [2];
    int          last_grant;

    always @(negedge csi_MCLK_clk) begin
        if (timeout_pulse) to_cnt++;
        if (!avs_a_waitrequest && (avs_a_read || avs_a_write) &&
            !avs_b_waitrequest && (avs_b_read || avs_b_write)) viol_cnt++;
        if (rsi_MRST_reset) begin
            cap_len = 0;
            ph      = 0;
            sdi     = 1'b0;
            srdy    = (resp_mode == 2);
        end else begin
            sdi  = 1'b0;
            srdy = (resp_mode == 2);
            if (sle) begin
                cap = {cap[63:0], sdo};
                cap_len++;
            end else if (cap_len != 0) begin
                frames.push_back(cap);
                flens.push_back(cap_len);
                cap_len = 0;
                if (cap[64]) rem_mem[cap[39:32]] = cap[31:0];
                else         prd = rem_mem[cap[39:32]];
                p_rd = !cap[64];
                if (resp_mode == 0) begin
                    ph   = 1;
                    pcnt = resp_delay;
                end
            end
            if (ph == 1) begin
                if (pcnt == 0) begin
                    srdy = 1'b1;
                    ph   = p_rd ? 2 : 0;
                end else begin
                    pcnt--;
                end
            end else if (ph == 2) begin
                sdi = prd[31 - pcnt];
                pcnt++;
                if (pcnt == 32) ph = 0;
            end
        end
    end

    task automatic drive(input int port, input bit rd, input bit wr,
                         input logic [7:0] a, input logic [31:0] d);
        if (port == 0) begin
            avs_a_read = rd; avs_a_write = wr; avs_a_address = a; avs_a_writedata = d;
        end else begin
            avs_b_read = rd; avs_b_write = wr; avs_b_address = a; avs_b_writedata = d;
        end
    endtask

    // Called at a falling edge with the request already driven; returns one cycle after DONE.
    task automatic wait_done(input int port, output int lat, output logic [31:0] rdv, output bit tov);
        lat = 0; rdv = '0; tov = 1'b0;
        forever begin
            #1;
            if (((port == 0) ? avs_a_waitrequest : avs_b_waitrequest) == 1'b0) begin
                rdv = (port == 0) ? avs_a_readdata : avs_b_readdata;
                tov = timeout_pulse;
                order_q.push_back(port);
                break;
            end
            if (lat >= 600) begin
                lat = -1;
                break;
            end
            @(negedge csi_MCLK_clk);
            lat++;
        end
        @(negedge csi_MCLK_clk);
    endtask

    task automatic apply_reset();
        @(negedge csi_MCLK_clk);
        rsi_MRST_reset = 1'b1;
        drive(0, 0, 0, 8'h00, 32'h0);
        drive(1, 0, 0, 8'h00, 32'h0);
        repeat (2) @(negedge csi_MCLK_clk);
        rsi_MRST_reset = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_grant = 1;
    endtask

    task automatic test_reset();
        @(negedge csi_MCLK_clk);
        rsi_MRST_reset = 1'b1;
        #1;
        vectors++; if (sle !== 1'b0) begin miscompares++; $display("FAIL reset_sle: got %b want 0", sle); end
        vectors++; if (sdo !== 1'b0) begin miscompares++; $display("FAIL reset_sdo: got %b want 0", sdo); end
        vectors++; if (timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout_pulse); end
        vectors++; if (avs_a_readdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata_a: got %h want 0", avs_a_readdata); end
        vectors++; if (avs_b_readdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata_b: got %h want 0", avs_b_readdata); end
        @(negedge csi_MCLK_clk);
        rsi_MRST_reset = 1'b0;
        @(negedge csi_MCLK_clk); #1;
        vectors++; if (avs_a_waitrequest !== 1'b0 || avs_b_waitrequest !== 1'b0) begin
            miscompares++; $display("FAIL reset_wait: got %b%b want 00", avs_a_waitrequest, avs_b_waitrequest); end
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_grant = 1;
    endtask

    task automatic test_write_frame();
        int lat; logic [31:0] rdv; bit tov; logic [64:0] ef;
        resp_mode = 2;
        frames.delete(); flens.delete();
        ef = {1'b1, 24'd0, 8'h12, 32'hCAFE_F00D};
        drive(0, 0, 1, 8'h12, 32'hCAFE_F00D);
        wait_done(0, lat, rdv, tov);
        drive(0, 0, 0, 8'h00, 32'h0);
        vectors++; if (lat != 68) begin miscompares++; $display("FAIL wr_latency: got %0d want 68", lat); end
        vectors++; if (frames.size() != 1 || flens[0] != 65) begin miscompares++;
            $display("FAIL wr_sle_len: got %0d frames len %0d want 1 frame len 65", frames.size(), (flens.size() > 0) ? flens[0] : 0); end
        vectors++; if (frames.size() < 1 || frames[0] !== ef) begin miscompares++;
            $display("FAIL wr_frame: got %h want %h", (frames.size() > 0) ? frames[0] : 65'h0, ef); end
        vectors++; if (rdv !== exp_rd[0]) begin miscompares++; $display("FAIL wr_rdata_kept: got %h want %h", rdv, exp_rd[0]); end
    endtask

    task automatic test_read_b();
        int lat; logic [31:0] rdv; bit tov; logic [64:0] ef;
        resp_mode = 0; resp_delay = 10;
        rem_mem[8'h05] = 32'hA5A5_0F0F;
        frames.delete(); flens.delete();
        ef = {1'b0, 24'd0, 8'h05, 32'd0};
        drive(1, 1, 0, 8'h05, 32'h1234_5678);
        wait_done(1, lat, rdv, tov);
        drive(1, 0, 0, 8'h00, 32'h0);
        exp_rd[1] = 32'hA5A5_0F0F;
        vectors++; if (lat != 110) begin miscompares++; $display("FAIL rd_latency: got %0d want 110", lat); end
        vectors++; if (rdv !== 32'hA5A5_0F0F) begin miscompares++; $display("FAIL rd_data_b: got %h want a5a50f0f", rdv); end
        vectors++; if (avs_a_readdata !== exp_rd[0]) begin miscompares++; $display("FAIL rd_other_port: got %h want %h", avs_a_readdata, exp_rd[0]); end
        vectors++; if (frames.size() != 1 || frames[0] !== ef) begin miscompares++;
            $display("FAIL rd_frame: got %h want %h", (frames.size() > 0) ? frames[0] : 65'h0, ef); end
    endtask

    task automatic test_rw_both();
        int lat; logic [31:0] rdv; bit tov; logic [64:0] ef;
        resp_mode = 2;
        frames.delete(); flens.delete();
        ef = {1'b1, 24'd0, 8'h7E, 32'h0BAD_F00D};
        drive(0, 1, 1, 8'h7E, 32'h0BAD_F00D);
        wait_done(0, lat, rdv, tov);
        drive(0, 0, 0, 8'h00, 32'h0);
        vectors++; if (lat != 68) begin miscompares++; $display("FAIL rw_latency: got %0d want 68", lat); end
        vectors++; if (frames.size() != 1 || frames[0] !== ef) begin miscompares++;
            $display("FAIL rw_frame: got %h want %h", (frames.size() > 0) ? frames[0] : 65'h0, ef); end
    endtask

    task automatic master_loop(input int port, input int n);
        int lat; logic [31:0] rdv; bit tov;
        for (int i = 0; i < n; i++) begin
            drive(port, 0, 1, 8'($urandom), $urandom);
            wait_done(port, lat, rdv, tov);
        end
        drive(port, 0, 0, 8'h00, 32'h0);
    endtask

    task automatic test_back_to_back();
        int v0;
        int want;
        apply_reset();
        resp_mode = 2;
        order_q.delete();
        v0 = viol_cnt;
        fork
            master_loop(0, 2);
            master_loop(1, 2);
        join
        vectors++; if (order_q.size() != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", order_q.size()); end
        for (int i = 0; i < 4 && i < order_q.size(); i++) begin
            want = i % 2;
            vectors++; if (order_q[i] != want) begin miscompares++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order_q[i], want); end
        end
        vectors++; if (viol_cnt != v0) begin miscompares++; $display("FAIL b2b_overlap: got %0d want 0", viol_cnt - v0); end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rdv; bit tov; int t0;
        resp_mode = 1;
        t0 = to_cnt;
        drive(0, 1, 0, 8'h33, 32'h0);
        wait_done(0, lat, rdv, tov);
        drive(0, 0, 0, 8'h00, 32'h0);
        // 65 frame cycles + 2 setup cycles, then 16 cycles of waiting
        vectors++; if (lat != 83) begin miscompares++; $display("FAIL to_latency: got %0d want 83", lat); end
        vectors++; if (rdv !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL to_rdata: got %h want deadbeef", rdv); end
        vectors++; if (tov !== 1'b1) begin miscompares++; $display("FAIL to_pulse_in_done: got %b want 1", tov); end
        vectors++; if (to_cnt - t0 != 1) begin miscompares++; $display("FAIL to_pulse_count: got %0d want 1", to_cnt - t0); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rdv; bit tov; logic [64:0] ef;
        resp_mode = 2;
        frames.delete(); flens.delete();
        ef = {1'b1, 24'd0, 8'hA5, 32'h1357_9BDF};
        drive(0, 0, 1, 8'hA5, 32'h1357_9BDF);
        repeat (32) @(posedge csi_MCLK_clk);
        #2;
        vectors++; if (sle !== 1'b1 || sdo !== ef[34]) begin miscompares++;
            $display("FAIL mid_bit30: got sle=%b sdo=%b want sle=1 sdo=%b", sle, sdo, ef[34]); end
        rsi_MRST_reset = 1'b1;
        #1;
        vectors++; if (sle !== 1'b0 || sdo !== 1'b0) begin miscompares++;
            $display("FAIL mid_abort: got sle=%b sdo=%b want 0 0", sle, sdo); end
        repeat (2) @(negedge csi_MCLK_clk);
        rsi_MRST_reset = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_grant = 1;
        wait_done(0, lat, rdv, tov);
        drive(0, 0, 0, 8'h00, 32'h0);
        vectors++; if (lat != 68) begin miscompares++; $display("FAIL mid_relatency: got %0d want 68", lat); end
        vectors++; if (frames.size() != 1 || flens[0] != 65 || frames[0] !== ef) begin miscompares++;
            $display("FAIL mid_fresh_frame: got %0d frames first %h want 1 frame %h",
                     frames.size(), (frames.size() > 0) ? frames[0] : 65'h0, ef); end
    endtask

    task automatic test_random();
        int sel, d, first, second, n;
        bit act [2];
        bit isrd [2];
        bit iswr [2];
        logic [7:0]  ad [2];
        logic [31:0] dt [2];
        int lat_o [2]; logic [31:0] rd_o [2]; bit to_o [2];
        int exp_lat [2];
        logic [64:0] ef [$];
        int seq [$];
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            rem_mem[i] = $urandom;
            ref_mem[i] = rem_mem[i];
        end
        resp_mode = 0;
        for (int r = 0; r < 12; r++) begin
            sel = $urandom_range(0, 2);
            act[0] = (sel != 1);
            act[1] = (sel != 0);
            for (int p = 0; p < 2; p++) begin
                int k;
                k = $urandom_range(0, 2);
                isrd[p] = (k != 1);
                iswr[p] = (k != 0);
                ad[p] = 8'($urandom);
                dt[p] = $urandom;
            end
            d = $urandom_range(0, 6);
            resp_delay = d;
            seq.delete(); ef.delete();
            if (act[0] && act[1]) begin
                first = (last_grant == 0) ? 1 : 0;
                second = 1 - first;
                seq.push_back(first); seq.push_back(second);
            end else begin
                seq.push_back(act[0] ? 0 : 1);
            end
            n = 0;
            foreach (seq[j]) begin
                int p;
                p = seq[j];
                n = n + (iswr[p] ? 68 : 100) + d + ((j > 0) ? 1 : 0);
                exp_lat[p] = n;
                if (iswr[p]) begin
                    ef.push_back({1'b1, 24'd0, ad[p], dt[p]});
                    ref_mem[ad[p]] = dt[p];
                end else begin
                    ef.push_back({1'b0, 24'd0, ad[p], 32'd0});
                    exp_rd[p] = ref_mem[ad[p]];
                end
                last_grant = p;
            end
            frames.delete(); flens.delete();
            fork
                begin
                    if (act[0]) begin
                        drive(0, isrd[0], iswr[0], ad[0], dt[0]);
                        wait_done(0, lat_o[0], rd_o[0], to_o[0]);
                        drive(0, 0, 0, 8'h00, 32'h0);
                    end
                end
                begin
                    if (act[1]) begin
                        drive(1, isrd[1], iswr[1], ad[1], dt[1]);
                        wait_done(1, lat_o[1], rd_o[1], to_o[1]);
                        drive(1, 0, 0, 8'h00, 32'h0);
                    end
                end
            join
            for (int p = 0; p < 2; p++) begin
                if (act[p]) begin
                    vectors++; if (lat_o[p] != exp_lat[p]) begin miscompares++;
                        $display("FAIL rnd%0d_lat_p%0d: got %0d want %0d", r, p, lat_o[p], exp_lat[p]); end
                    vectors++; if (rd_o[p] !== exp_rd[p]) begin miscompares++;
                        $display("FAIL rnd%0d_rdata_p%0d: got %h want %h", r, p, rd_o[p], exp_rd[p]); end
                end
            end
            vectors++; if (frames.size() != ef.size()) begin miscompares++;
                $display("FAIL rnd%0d_frame_count: got %0d want %0d", r, frames.size(), ef.size()); end
            for (int j = 0; j < ef.size() && j < frames.size(); j++) begin
                vectors++; if (frames[j] !== ef[j]) begin miscompares++;
                    $display("FAIL rnd%0d_frame%0d: got %h want %h", r, j, frames[j], ef[j]); end
            end
        end
    endtask

    initial begin
        rsi_MRST_reset = 1'b1;
        drive(0, 0, 0, 8'h00, 32'h0);
        drive(1, 0, 0, 8'h00, 32'h0);
        test_reset();
        test_write_frame();
        test_read_b();
        test_rw_both();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/qsys_serial_arbiter.md
Name: qsys_serial_arbiter

Overview:
Two-port Avalon-MM slave front end that shares one serial link (sdo/sdi/sle/srdy) between two Qsys masters.
- Arbitrates requests round-robin and latches the winner.
- Serialises a 65-bit command frame, waits for the remote srdy handshake and, for reads, shifts back 32 data bits.
- Holds each master on waitrequest until its own transaction completes.
- Sits between the Qsys interconnect and the off-chip serial peripheral, replacing direct single-master access to the link.

Parameters:
- TIMEOUT, 1024: max cycles spent in WAIT_RDY before forced completion (min 2, max 65535).
- ERR_DATA, 32'hDEAD_BEEF: readdata returned on a timed-out read.

Ports:
- rsi_MRST_reset  in  1  reset, asynchronous, active-high.
- csi_MCLK_clk  in  1  clock; also the serial bit clock.
- avs_a_address  in  8  port A word address.
- avs_a_writedata  in  32  port A write data.
- avs_a_write  in  1  port A write request.
- avs_a_read  in  1  port A read request.
- avs_a_readdata  out  32  port A read data.
- avs_a_waitrequest  out  1  port A stall.
- avs_b_address, avs_b_writedata, avs_b_write, avs_b_read, avs_b_readdata, avs_b_waitrequest: same as port A, for port B.
- sdo  out  1  serial data out.
- sle  out  1  frame enable, high while sdo carries frame bits.
- sdi  in  1  serial data in (read return).
- clk  out  1  serial clock, equal to csi_MCLK_clk.
- srdy  in  1  remote ready.
- timeout_pulse  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state=IDLE; sdo, sle, timeout_pulse = 0; both readdata = 0; last_grant = B, so A wins the first tie; all counters 0. Reset mid-frame aborts immediately with sle=0. A request still asserted after reset is re-arbitrated from IDLE.
- req_x = avs_x_read | avs_x_write. If read and write are both asserted, treat as write.
- avs_x_waitrequest = req_x & ~(state==DONE & grant==x). Combinational. Never low for a pending request outside its own DONE cycle.
- IDLE: if any req_x, go to LOAD.
  - grant = the sole requester; on a tie, the port not equal to last_grant.
- LOAD (1 cycle): latch frame[64:0] = {rw, 24'b0, address, writedata or 32'b0}, with rw = 1 for write. Bit counter = 0.
- SHIFT (65 cycles): registered outputs sle=1, sdo=frame[64-count], MSB first.
  - At count 64, go to WAIT_RDY. The cycle after the last bit, sle=0 and sdo=0.
- WAIT_RDY: timer counts up each cycle.
  - srdy=1: write goes to DONE; read goes to RECV.
  - timer == TIMEOUT-1 with srdy still 0: pulse timeout_pulse, force readdata latch = ERR_DATA, go to DONE.
- RECV (32 cycles): shift_in = {shift_in[30:0], sdi}, MSB first. srdy is ignored. Then go to DONE.
- DONE (1 cycle): granted port's readdata <= shift_in (reads), or ERR_DATA on timeout; the other port's readdata is unchanged. Granted waitrequest = 0. last_grant = grant. Return to IDLE.
- Address/writedata are sampled only in LOAD; later changes by the master are ignored.
- Requests arriving mid-transaction wait; there is no pre-emption.
- Back-to-back: minimum 1 IDLE cycle between frames. A continuously requesting pair alternates A, B, A, B.
- Latency, request present in IDLE at cycle 0 and srdy already high:
  - write: waitrequest low at cycle 68.
  - read: waitrequest low at cycle 100.

Test Plan:
- Port A write addr=8'h12 data=32'hCAFE_F00D, srdy tied 1 -> sle high exactly 65 cycles; sdo stream = 1, 24×0, 00010010, then CAFEF00D MSB first; avs_a_waitrequest low at cycle 68 only.
- Port B read addr=8'h05, srdy rises 10 cycles after sle falls, sdi drives 32'hA5A5_0F0F MSB first -> avs_b_readdata = 32'hA5A50F0F in DONE; avs_a_readdata unchanged.
- A and B both request in the same cycle, held -> order A, B, A, B; each port's waitrequest never low during the other port's DONE.
- Read with srdy stuck 0, TIMEOUT=16 -> timeout_pulse one cycle, readdata = 32'hDEADBEEF, state back to IDLE, no RECV.
- Assert reset at SHIFT bit 30 with A requesting -> sle=0 and sdo=0 immediately; after release, a full fresh 65-bit frame for A.
- A raises read and write together -> frame rw bit = 1 and writedata is transmitted.
